bit_serializer: RTL and testbench

Parallel-to-serial front end for the single-bit Mealy sequence detectors. It accepts W-bit words over a valid/ready handshake and drives them out one bit per clock on `x`, which connects directly to the downstream FSM's `x` input. `x_valid` and `x_last` let the consumer or the bench frame each word. Back-to-back words stream with no idle gap.

---
 rtl/bit_serializer_if.sv | 23 ++
 rtl/bit_serializer.sv | 128 ++++++++++++
 tb/tb_bit_serializer.sv | 179 +++++++++++++++++
 3 files changed

// File: rtl/bit_serializer_if.sv
// Handshake and serial-output bundle for bit_serializer.
// The producer or bench holds the master side; the serializer holds the slave side.
interface bit_serializer_if #(
    parameter int W = 8
);
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         x;
    logic         x_valid;
    logic         x_last;
    logic         busy;

    modport master (
        output in_data, in_valid,
        input  in_ready, x, x_valid, x_last, busy
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, x, x_valid, x_last, busy
    );
endinterface

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: W-bit words in over valid/ready, one bit per clock out on x.
// Define BIT_SERIALIZER_PARITY_EN to append an even-parity bit after each word.
module bit_serializer #(
    parameter int   W         = 8,
    parameter bit   MSB_FIRST = 1'b0,
    parameter logic IDLE_BIT  = 1'b0
) (
    input logic             clk,
    input logic             rst,
    bit_serializer_if.slave bus
);
    localparam int CW = $clog2(W);

`ifdef BIT_SERIALIZER_PARITY_EN
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, PAR = 2'd2} state_t;
`else
    typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1} state_t;
`endif

    state_t          state_q, state_d;
    logic [W-1:0]    sreg_q, sreg_d;
    logic [CW-1:0]   cnt_q, cnt_d;
`ifdef BIT_SERIALIZER_PARITY_EN
    logic            par_q, par_d;
`endif

    logic            cnt_end;
    logic            last_bit;
    logic            ready;
    logic            hs;
    logic            x_bit;

    // Everything driven outward depends only on registered state.
    always_comb begin
        cnt_end = (cnt_q == CW'(W - 1));
`ifdef BIT_SERIALIZER_PARITY_EN
        last_bit = (state_q == PAR);
`else
        last_bit = (state_q == SHIFT) && cnt_end;
`endif
        ready = (state_q == IDLE) || last_bit;
        x_bit = IDLE_BIT;
        case (state_q)
            SHIFT:   x_bit = MSB_FIRST ? sreg_q[W-1] : sreg_q[0];
`ifdef BIT_SERIALIZER_PARITY_EN
            PAR:     x_bit = par_q;
`endif
            default: x_bit = IDLE_BIT;
        endcase
    end

    assign hs           = bus.in_valid & ready;
    assign bus.in_ready = ready;
    assign bus.x        = x_bit;
    assign bus.x_valid  = (state_q != IDLE);
    assign bus.busy     = (state_q != IDLE);
    assign bus.x_last   = last_bit;

    always_comb begin
        state_d = state_q;
        sreg_d  = sreg_q;
        cnt_d   = cnt_q;
`ifdef BIT_SERIALIZER_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            IDLE: begin
                if (hs) begin
                    state_d = SHIFT;
                    sreg_d  = bus.in_data;
                    cnt_d   = '0;
`ifdef BIT_SERIALIZER_PARITY_EN
                    par_d   = ^bus.in_data;
`endif
                end
            end
            SHIFT: begin
                sreg_d = MSB_FIRST ? {sreg_q[W-2:0], 1'b0} : {1'b0, sreg_q[W-1:1]};
                cnt_d  = cnt_q + 1'b1;
                if (cnt_end) begin
`ifdef BIT_SERIALIZER_PARITY_EN
                    state_d = PAR;
`else
                    // A handshake on the last bit reloads so words stream gap-free.
                    if (hs) begin
                        state_d = SHIFT;
                        sreg_d  = bus.in_data;
                        cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
`endif
                end
            end
`ifdef BIT_SERIALIZER_PARITY_EN
            PAR: begin
                if (hs) begin
                    state_d = SHIFT;
                    sreg_d  = bus.in_data;
                    cnt_d   = '0;
                    par_d   = ^bus.in_data;
                end else begin
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            sreg_q  <= '0;
            cnt_q   <= '0;
`ifdef BIT_SERIALIZER_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            cnt_q   <= cnt_d;
`ifdef BIT_SERIALIZER_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end
endmodule

// File: tb/tb_bit_serializer.sv
// Bench for bit_serializer: LSB-first and MSB-first instances checked against a
// queue-of-expected-bits model built from each accepted word.
module tb_bit_serializer;
    localparam int W = 8;
`ifdef BIT_SERIALIZER_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif
    localparam logic IDLE0 = 1'b0;
    localparam logic IDLE1 = 1'b1;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bit_serializer_if #(.W(W)) bus0 ();
    bit_serializer_if #(.W(W)) bus1 ();

    bit_serializer #(.W(W), .MSB_FIRST(1'b0), .IDLE_BIT(IDLE0)) dut0 (
        .clk(clk), .rst(rst), .bus(bus0)
    );
    bit_serializer #(.W(W), .MSB_FIRST(1'b1), .IDLE_BIT(IDLE1)) dut1 (
        .clk(clk), .rst(rst), .bus(bus1)
    );

    typedef struct packed {
        logic b;
        logic last;
    } ebit_t;

    ebit_t q0[$];
    ebit_t q1[$];
    int    tests = 0;
    int    fails = 0;
    int    cyc   = 0;
    logic  acc;

    // Wire image of one word: data bits in send order, then optional parity.
    function automatic void push_word(input logic [W-1:0] d);
        for (int i = 0; i < W; i++) begin
            q0.push_back('{b: d[i],       last: (i == W - 1) && !PAR_EN});
            q1.push_back('{b: d[W-1-i],   last: (i == W - 1) && !PAR_EN});
        end
        if (PAR_EN) begin
            q0.push_back('{b: ^d, last: 1'b1});
            q1.push_back('{b: ^d, last: 1'b1});
        end
    endfunction

    task automatic check(input string tag, input logic obs, input logic exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic check_all();
        logic v0, v1;
        v0 = (q0.size() != 0);
        v1 = (q1.size() != 0);
        check("x_lsb",      bus0.x,        v0 ? q0[0].b : IDLE0);
        check("xvalid_lsb", bus0.x_valid,  v0);
        check("xlast_lsb",  bus0.x_last,   v0 ? q0[0].last : 1'b0);
        check("ready_lsb",  bus0.in_ready, !v0 || q0[0].last);
        check("busy_lsb",   bus0.busy,     v0);
        check("x_msb",      bus1.x,        v1 ? q1[0].b : IDLE1);
        check("xvalid_msb", bus1.x_valid,  v1);
        check("xlast_msb",  bus1.x_last,   v1 ? q1[0].last : 1'b0);
        check("ready_msb",  bus1.in_ready, !v1 || q1[0].last);
    endtask

    // One clock: drive inputs, model the edge, then check outputs at the falling edge.
    task automatic step(input logic v, input logic [W-1:0] d);
        logic rdy;
        bus0.in_valid = v;
        bus0.in_data  = d;
        bus1.in_valid = v;
        bus1.in_data  = d;
        rdy = (q0.size() == 0) || q0[0].last;
        @(posedge clk);
        acc = v && rdy && !rst;
        if (q0.size() != 0) begin
            q0.delete(0);
            q1.delete(0);
        end
        if (acc) push_word(d);
        @(negedge clk);
        cyc++;
        check_all();
    endtask

    task automatic send_word(input logic [W-1:0] d);
        int n;
        n = 0;
        acc = 1'b0;
        while (!acc && n < 3 * W) begin
            step(1'b1, d);
            n++;
        end
        check("accept_timeout", acc, 1'b1);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, W'($urandom));
    endtask

    logic         pend;
    logic [W-1:0] pd;

    initial begin
        rst = 1'b1;
        bus0.in_valid = 1'b0; bus0.in_data = '0;
        bus1.in_valid = 1'b0; bus1.in_data = '0;
        #2;
        check_all();
        @(negedge clk);
        check_all();
        rst = 1'b0;
        idle(2);

        // Single word, in_data scrambled while in flight.
        send_word(8'hA5);
        idle(W + 3);

        // Back-to-back with in_valid held high.
        send_word(8'h01);
        send_word(8'hFF);
        idle(W + 3);

        // MSB-first pattern on dut1.
        send_word(8'hC3);
        idle(W + 3);

        // Second word raised mid-word waits for the last bit.
        send_word(8'hF0);
        idle(2);
        send_word(8'h55);
        idle(W + 3);

        // Asynchronous reset after three bits.
        send_word(8'hA5);
        idle(2);
        #2;
        rst = 1'b1;
        q0.delete();
        q1.delete();
        #1;
        check_all();
        @(negedge clk);
        rst = 1'b0;
        idle(1);
        send_word(8'h3C);
        idle(W + 3);

        // Parity-sensitive words.
        send_word(8'h07);
        idle(W + 3);
        send_word(8'h03);
        idle(W + 3);

        // Randomized traffic; producer holds a pending word until accepted.
        pend = 1'b0;
        pd   = '0;
        for (int i = 0; i < 400; i++) begin
            if (!pend && ($urandom_range(0, 2) == 0)) begin
                pend = 1'b1;
                pd   = W'($urandom);
            end
            step(pend, pend ? pd : W'($urandom));
            if (acc) pend = 1'b0;
        end
        idle(2 * W + 4);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
